wb_initiator: RTL

- Wishbone classic-cycle bus initiator: turns one load/store request from a core-side valid/ready interface into one single-beat Wishbone read or write toward word-addressed, byte-laned responders such as the on-chip memory.
- Handles byte-address to word-address conversion, sel lane generation, write-data lane steering, read-data extraction with sign/zero extension, and misalignment rejection.
- Sits between the CPU load/store/fetch logic and the Wishbone interconnect.

---
 rtl/wb_initiator_if.sv | 34 +++
 rtl/wb_initiator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator_if.sv
// Wishbone classic-cycle signal bundle between the load/store initiator and its responders.
// The master modport belongs to the initiator and the slave modport belongs to the responder.
interface wb_initiator_if;
  logic [29:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic        ack_i;

  modport master (
    output adr_o,
    output dat_o,
    output sel_o,
    output cyc_o,
    output stb_o,
    output we_o,
    input  dat_i,
    input  ack_i
  );

  modport slave (
    input  adr_o,
    input  dat_o,
    input  sel_o,
    input  cyc_o,
    input  stb_o,
    input  we_o,
    output dat_i,
    output ack_i
  );
endinterface

// File: rtl/wb_initiator.sv
// Single-beat Wishbone classic initiator for core load/store requests (byte/half/word lanes).
// Optional bus timeout is enabled by defining WB_INITIATOR_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  wb_initiator_if.master wb
);

  if ((TIMEOUT_CYCLES < 32'd2) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
    $error("wb_initiator: TIMEOUT_CYCLES must lie in 2..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size 11 is illegal; halves need an even address, words a word-aligned one.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] f_sel(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] sel;
    case (size)
      SZ_BYTE: sel = 4'b0001 << off;
      SZ_HALF: sel = 4'b0011 << off;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Replicate the right-aligned store data across every lane so sel alone picks the target.
  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] dat;
    case (size)
      SZ_BYTE: dat = {4{wdata[7:0]}};
      SZ_HALF: dat = {2{wdata[15:0]}};
      default: dat = wdata;
    endcase
    return dat;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] dat, input logic [1:0] size,
                                         input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = dat[7:0];
      2'd1:    b = dat[15:8];
      2'd2:    b = dat[23:16];
      default: b = dat[31:24];
    endcase
    h = off[1] ? dat[31:16] : dat[15:0];
    case (size)
      SZ_BYTE: res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = dat;
    endcase
    return res;
  endfunction

  state_t      state_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [31:0] resp_rdata_r;
  logic [29:0] adr_r;
  logic [31:0] dat_r;
  logic [3:0]  sel_r;
  logic        cyc_r;
  logic        stb_r;
  logic        we_r;
  logic [1:0]  size_r;
  logic [1:0]  off_r;
  logic        uns_r;
  logic        req_fire_s;
  logic        misalign_s;

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST_C = 16'(TIMEOUT_CYCLES - 32'd1);
  logic [15:0] timer_r;
`endif

  assign req_ready  = (state_r == ST_IDLE);
  assign req_fire_s = req_valid & req_ready;
  assign misalign_s = f_misaligned(req_size, req_addr[1:0]);

  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign wb.adr_o   = adr_r;
  assign wb.dat_o   = dat_r;
  assign wb.sel_o   = sel_r;
  assign wb.cyc_o   = cyc_r;
  assign wb.stb_o   = stb_r;
  assign wb.we_o    = we_r;

  // Request/bus/response sequencer with all outputs registered.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= ST_IDLE;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
      adr_r        <= 30'd0;
      dat_r        <= 32'd0;
      sel_r        <= 4'd0;
      cyc_r        <= 1'b0;
      stb_r        <= 1'b0;
      we_r         <= 1'b0;
      size_r       <= 2'd0;
      off_r        <= 2'd0;
      uns_r        <= 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
      timer_r      <= 16'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_fire_s) begin
            if (misalign_s) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'd0;
              state_r      <= ST_RESP;
            end else begin
              cyc_r   <= 1'b1;
              stb_r   <= 1'b1;
              we_r    <= req_we;
              adr_r   <= req_addr[31:2];
              sel_r   <= f_sel(req_size, req_addr[1:0]);
              dat_r   <= f_wdata(req_size, req_wdata);
              size_r  <= req_size;
              off_r   <= req_addr[1:0];
              uns_r   <= req_unsigned;
`ifdef WB_INITIATOR_TIMEOUT_EN
              timer_r <= 16'd0;
`endif
              state_r <= ST_BUS;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUS: begin
          // stb must fall right after ack, since the responder keeps ack up while stb is high.
          if (wb.ack_i) begin
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            we_r         <= 1'b0;
            sel_r        <= 4'd0;
            resp_rdata_r <= we_r ? 32'd0 : f_load(wb.dat_i, size_r, off_r, uns_r);
            resp_err_r   <= 1'b0;
            resp_valid_r <= 1'b1;
            state_r      <= ST_RESP;
`ifdef WB_INITIATOR_TIMEOUT_EN
          end else if (timer_r == TMO_LAST_C) begin
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            we_r         <= 1'b0;
            sel_r        <= 4'd0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b1;
            resp_valid_r <= 1'b1;
            state_r      <= ST_RESP;
          end else begin
            timer_r <= timer_r + 16'd1;
          end
`else
          end else begin
            state_r <= ST_BUS;
          end
`endif
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          cyc_r        <= 1'b0;
          stb_r        <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
